// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and its width.
package serial_sub_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_fsm_sub_digit.sv
// sub_digit: combinational DIGIT-wide subtract slice (a - b - bi -> d, bo),
// built as a ripple of per-bit half-subtractor terms.
module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    // Ripple the borrow LSB to MSB; hd/hb are the half-subtractor difference/borrow of a[i]-b[i].
    always_comb begin
        logic br;
        logic hd;
        logic hb;
        d  = '0;
        br = bi;
        hd = 1'b0;
        hb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            hd   = a[i] ^ b[i];
            hb   = ~a[i] & b[i];
            d[i] = hd ^ br;
            br   = hb | (~hd & br);
        end
        bo = br;
    end

endmodule

// File: rtl/serial_sub_fsm.sv
// serial_sub_fsm: multi-cycle subtractor Y = A - B - bin, DIGIT bits per enabled clock.
// Start/busy/done handshake; en=0 freezes every register in place.
// Optional macro SERIAL_SUB_SAT_EN: when defined, a final borrow clamps Y to 0
// (borrow still reports 1); when undefined, Y wraps modulo 2^WIDTH.
module serial_sub_fsm
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             borrow
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
        $error("serial_sub_fsm: DIGIT must be >= 1 and divide WIDTH");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [WIDTH-1:0]   res_next;
    logic               brw;
    logic [DIGIT-1:0]   dig_d;
    logic               dig_bo;

    sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
        .a  (a_sr[DIGIT-1:0]),
        .b  (b_sr[DIGIT-1:0]),
        .bi (brw),
        .d  (dig_d),
        .bo (dig_bo)
    );

    // New digit enters at the MSB end; after N digits the LSB digit has reached bit 0.
    assign res_next = WIDTH'({dig_d, res_sr} >> DIGIT);

    // Control FSM, operand shifters, borrow chain and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            Y      <= '0;
            borrow <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        brw    <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    brw    <= dig_bo;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
`ifdef SERIAL_SUB_SAT_EN
                        Y <= dig_bo ? '0 : res_next;
`else
                        Y <= res_next;
`endif
                        borrow <= dig_bo;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
